bus_responder: RTL and testbench

//  Memory/I-O slave on the CPU's external bus; the CPU core is the bus master.

---
 rtl/bus_resp_pkg.sv | 29 ++
 rtl/resp_timer.sv | 123 ++++++++++++
 rtl/bus_responder.sv | 95 +++++++++
 tb/tb_bus_responder.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_resp_pkg.sv
// Shared constants for the bus responder: I/O window offsets, timer CTRL/STAT
// bit positions and the value returned for unmapped reads.
// Timer-only items exist only when BUS_RESP_TIMER_EN is defined.
package bus_resp_pkg;

  // Offsets inside the 8-byte I/O window (address[2:0])
  localparam logic [2:0] OFF_TLO   = 3'd0;
  localparam logic [2:0] OFF_THI   = 3'd1;
  localparam logic [2:0] OFF_CTRL  = 3'd2;
  localparam logic [2:0] OFF_STAT  = 3'd3;
  localparam logic [2:0] OFF_CNTLO = 3'd4;
  localparam logic [2:0] OFF_CNTHI = 3'd5;
  localparam logic [2:0] OFF_OUTP  = 3'd6;
  localparam logic [2:0] OFF_RSVD  = 3'd7;

  // Value driven for reads that hit nothing
  localparam logic [7:0] UNMAPPED_RD = 8'hFF;

`ifdef BUS_RESP_TIMER_EN
  // CTRL register bit positions
  localparam int unsigned CTRL_EN = 0;
  localparam int unsigned CTRL_IE = 1;
  localparam int unsigned CTRL_AR = 2;

  // STAT register bit positions
  localparam int unsigned STAT_EXP = 0;
`endif

endpackage

// File: rtl/resp_timer.sv
// 16-bit down-counting interval timer for the bus responder I/O window.
// Holds reload value, counter, CTRL (EN/IE/AR), sticky EXP flag and the
// CNTHI hold latch used for coherent 16-bit counter reads.
// Only built when BUS_RESP_TIMER_EN is defined.
`ifdef BUS_RESP_TIMER_EN
module resp_timer
  import bus_resp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic       rd,
  input  logic [2:0] offset,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq_n
);

  logic [15:0] reload_q, reload_d;
  logic [15:0] cnt_q, cnt_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        ar_q, ar_d;
  logic        exp_q, exp_d;
  logic [7:0]  hold_q, hold_d;
  logic        expire;

  // Next-state: counting first, then register writes so a bus write wins,
  // except a W1C on STAT which loses to a simultaneous expiry.
  always_comb begin
    reload_d = reload_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    ie_d     = ie_q;
    ar_d     = ar_q;
    exp_d    = exp_q;
    hold_d   = hold_q;
    expire   = en_q && (cnt_q == 16'h0000);

    if (en_q) begin
      if (!expire) begin
        cnt_d = cnt_q - 16'd1;
      end else if (ar_q) begin
        cnt_d = reload_q;
      end else begin
        en_d = 1'b0;
      end
    end

    if (wr && (offset == OFF_STAT) && wdata[STAT_EXP]) begin
      exp_d = 1'b0;
    end
    if (expire) begin
      exp_d = 1'b1;
    end

    if (wr) begin
      case (offset)
        OFF_TLO: reload_d[7:0] = wdata;
        OFF_THI: begin
          reload_d[15:8] = wdata;
          cnt_d          = {wdata, reload_q[7:0]};
          exp_d          = 1'b0;
        end
        OFF_CTRL: begin
          en_d = wdata[CTRL_EN];
          ie_d = wdata[CTRL_IE];
          ar_d = wdata[CTRL_AR];
        end
        default: ;
      endcase
    end

    // Reading CNTLO freezes the high byte so CNTHI pairs with it
    if (rd && (offset == OFF_CNTLO)) begin
      hold_d = cnt_q[15:8];
    end
  end

  // Timer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_q <= 16'h0000;
      cnt_q    <= 16'h0000;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      ar_q     <= 1'b0;
      exp_q    <= 1'b0;
      hold_q   <= 8'h00;
    end else begin
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      ie_q     <= ie_d;
      ar_q     <= ar_d;
      exp_q    <= exp_d;
      hold_q   <= hold_d;
    end
  end

  // Register readback; offsets 6 and 7 are handled by the top level
  always_comb begin
    rdata = 8'h00;
    case (offset)
      OFF_TLO:   rdata = reload_q[7:0];
      OFF_THI:   rdata = reload_q[15:8];
      OFF_CTRL: begin
        rdata[CTRL_EN] = en_q;
        rdata[CTRL_IE] = ie_q;
        rdata[CTRL_AR] = ar_q;
      end
      OFF_STAT:  rdata[STAT_EXP] = exp_q;
      OFF_CNTLO: rdata = cnt_q[7:0];
      OFF_CNTHI: rdata = hold_q;
      default:   rdata = 8'h00;
    endcase
  end

  // Straight from flops, so no decode glitches reach the core
  assign irq_n = ~(exp_q & ie_q);

endmodule
`endif

// File: rtl/bus_responder.sv
// Bus slave for the CPU external bus: address decode, RAM, output port and
// registered read data. The interval timer is present only when
// BUS_RESP_TIMER_EN is defined; otherwise its offsets read 00 and irq is idle.
module bus_responder
  import bus_resp_pkg::*;
#(
  parameter int unsigned RAM_AW  = 10,
  parameter logic [15:0] IO_BASE = 16'hD000
) (
  input  logic        ph2,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  data_wr,
  input  logic        rw,
  input  logic        valid,
  output logic [7:0]  data_rd,
  output logic [7:0]  out_port,
  output logic        irq_n
);

  logic [7:0] ram_q [0:(2**RAM_AW)-1];
  logic       ram_sel;
  logic       io_hit;
  logic [2:0] io_off;
  logic       wr_stb;
  logic       rd_stb;
  logic [7:0] timer_rdata;
  logic [7:0] io_rd;
  logic [7:0] rd_val;

  assign ram_sel = (address[15:RAM_AW] == '0);
  assign io_hit  = (address[15:3] == IO_BASE[15:3]) && !ram_sel;
  assign io_off  = address[2:0];
  assign wr_stb  = valid && !rw;
  assign rd_stb  = valid && rw;

`ifdef BUS_RESP_TIMER_EN
  resp_timer u_timer (
    .clk    (ph2),
    .rst    (reset),
    .wr     (wr_stb && io_hit),
    .rd     (rd_stb && io_hit),
    .offset (io_off),
    .wdata  (data_wr),
    .rdata  (timer_rdata),
    .irq_n  (irq_n)
  );
`else
  assign timer_rdata = 8'h00;
  assign irq_n       = 1'b1;
`endif

  // Read data selection for the addressed target
  always_comb begin
    io_rd = 8'h00;
    case (io_off)
      OFF_TLO, OFF_THI, OFF_CTRL, OFF_STAT, OFF_CNTLO, OFF_CNTHI: io_rd = timer_rdata;
      OFF_OUTP: io_rd = out_port;
      OFF_RSVD: io_rd = 8'h00;
      default:  io_rd = 8'h00;
    endcase
    rd_val = UNMAPPED_RD;
    if (ram_sel) begin
      rd_val = ram_q[address[RAM_AW-1:0]];
    end else if (io_hit) begin
      rd_val = io_rd;
    end
  end

  // RAM array: contents survive reset, but no write lands while reset is high
  always_ff @(posedge ph2) begin
    if (!reset && wr_stb && ram_sel) begin
      ram_q[address[RAM_AW-1:0]] <= data_wr;
    end
  end

  // Output port register
  always_ff @(posedge ph2 or posedge reset) begin
    if (reset) begin
      out_port <= 8'h00;
    end else if (wr_stb && io_hit && (io_off == OFF_OUTP)) begin
      out_port <= data_wr;
    end
  end

  // Read data register; holds until the next read cycle
  always_ff @(posedge ph2 or posedge reset) begin
    if (reset) begin
      data_rd <= 8'h00;
    end else if (rd_stb) begin
      data_rd <= rd_val;
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Directed self-checking bench for bus_responder. Timer scenarios are built
// when BUS_RESP_TIMER_EN is defined; otherwise the timer-absent behaviour is checked.
module tb_bus_responder;

  logic        ph2;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  data_wr;
  logic        rw;
  logic        valid;
  logic [7:0]  data_rd;
  logic [7:0]  out_port;
  logic        irq_n;

  int tests_run;
  int tests_failed;

  localparam logic [15:0] A_TLO   = 16'hD000;
  localparam logic [15:0] A_THI   = 16'hD001;
  localparam logic [15:0] A_CTRL  = 16'hD002;
  localparam logic [15:0] A_STAT  = 16'hD003;
  localparam logic [15:0] A_CNTLO = 16'hD004;
  localparam logic [15:0] A_CNTHI = 16'hD005;
  localparam logic [15:0] A_OUTP  = 16'hD006;
  localparam logic [15:0] A_RSVD  = 16'hD007;

  bus_responder dut (
    .ph2      (ph2),
    .reset    (reset),
    .address  (address),
    .data_wr  (data_wr),
    .rw       (rw),
    .valid    (valid),
    .data_rd  (data_rd),
    .out_port (out_port),
    .irq_n    (irq_n)
  );

  initial begin
    ph2 = 1'b0;
    forever #5 ph2 = ~ph2;
  end

  // Each bus task starts and ends 1 time unit after a rising edge
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    address = a;
    data_wr = d;
    rw      = 1'b0;
    valid   = 1'b1;
    @(posedge ph2);
    #1;
    valid   = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    address = a;
    rw      = 1'b1;
    valid   = 1'b1;
    @(posedge ph2);
    #1;
    valid   = 1'b0;
    d       = data_rd;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ph2);
    #1;
  endtask

  task automatic test_reset;
    tests_run++;
    if (data_rd !== 8'h00) begin
      tests_failed++; $display("FAIL reset_data_rd: got %h want 00", data_rd);
    end
    tests_run++;
    if (out_port !== 8'h00) begin
      tests_failed++; $display("FAIL reset_out_port: got %h want 00", out_port);
    end
    tests_run++;
    if (irq_n !== 1'b1) begin
      tests_failed++; $display("FAIL reset_irq_n: got %b want 1", irq_n);
    end
  endtask

  task automatic test_ram;
    logic [7:0] d;
    bus_write(16'h0042, 8'hA5);
    bus_read(16'h0042, d);
    tests_run++;
    if (d !== 8'hA5) begin
      tests_failed++; $display("FAIL ram_0042: got %h want A5", d);
    end
    bus_read(16'h8000, d);
    tests_run++;
    if (d !== 8'hFF) begin
      tests_failed++; $display("FAIL unmapped_8000: got %h want FF", d);
    end
    bus_write(16'h03FF, 8'h3C);
    bus_read(16'h03FF, d);
    tests_run++;
    if (d !== 8'h3C) begin
      tests_failed++; $display("FAIL ram_top_03ff: got %h want 3C", d);
    end
    bus_write(16'h0000, 8'h11);
    bus_write(16'h0400, 8'h22);
    bus_read(16'h0000, d);
    tests_run++;
    if (d !== 8'h11) begin
      tests_failed++; $display("FAIL ram_no_alias_0400: got %h want 11", d);
    end
    bus_read(16'h0400, d);
    tests_run++;
    if (d !== 8'hFF) begin
      tests_failed++; $display("FAIL unmapped_0400: got %h want FF", d);
    end
    // data_rd must hold across writes and idle cycles
    bus_write(16'h0042, 8'h5A);
    idle(2);
    tests_run++;
    if (data_rd !== 8'hFF) begin
      tests_failed++; $display("FAIL data_rd_hold: got %h want FF", data_rd);
    end
    // valid=0 with a write pattern on the bus must not change RAM
    address = 16'h0042;
    data_wr = 8'h77;
    rw      = 1'b0;
    valid   = 1'b0;
    idle(1);
    bus_read(16'h0042, d);
    tests_run++;
    if (d !== 8'h5A) begin
      tests_failed++; $display("FAIL valid_low_no_write: got %h want 5A", d);
    end
  endtask

  task automatic test_io;
    logic [7:0] d;
    bus_write(A_OUTP, 8'h5A);
    tests_run++;
    if (out_port !== 8'h5A) begin
      tests_failed++; $display("FAIL outp_write: got %h want 5A", out_port);
    end
    bus_read(A_OUTP, d);
    tests_run++;
    if (d !== 8'h5A) begin
      tests_failed++; $display("FAIL outp_read: got %h want 5A", d);
    end
    bus_write(A_RSVD, 8'hFF);
    bus_read(A_RSVD, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++; $display("FAIL rsvd_read: got %h want 00", d);
    end
    bus_write(16'hD00E, 8'h99);
    tests_run++;
    if (out_port !== 8'h5A) begin
      tests_failed++; $display("FAIL outp_alias_d00e: got %h want 5A", out_port);
    end
    bus_read(16'hD008, d);
    tests_run++;
    if (d !== 8'hFF) begin
      tests_failed++; $display("FAIL unmapped_d008: got %h want FF", d);
    end
  endtask

`ifdef BUS_RESP_TIMER_EN
  task automatic test_timer_periodic;
    logic [7:0] d;
    bus_write(A_TLO, 8'h03);
    bus_write(A_THI, 8'h00);
    bus_write(A_CTRL, 8'h07);
    idle(3);
    tests_run++;
    if (irq_n !== 1'b1) begin
      tests_failed++; $display("FAIL periodic_edge3_irq: got %b want 1", irq_n);
    end
    idle(1);
    tests_run++;
    if (irq_n !== 1'b0) begin
      tests_failed++; $display("FAIL periodic_edge4_irq: got %b want 0", irq_n);
    end
    bus_write(A_STAT, 8'h01);
    tests_run++;
    if (irq_n !== 1'b1) begin
      tests_failed++; $display("FAIL periodic_w1c_irq: got %b want 1", irq_n);
    end
    idle(2);
    tests_run++;
    if (irq_n !== 1'b1) begin
      tests_failed++; $display("FAIL periodic_edge7_irq: got %b want 1", irq_n);
    end
    idle(1);
    tests_run++;
    if (irq_n !== 1'b0) begin
      tests_failed++; $display("FAIL periodic_edge8_irq: got %b want 0", irq_n);
    end
    bus_read(A_STAT, d);
    tests_run++;
    if (d !== 8'h01) begin
      tests_failed++; $display("FAIL periodic_stat: got %h want 01", d);
    end
    bus_write(A_CTRL, 8'h00);
    bus_write(A_STAT, 8'h01);
    tests_run++;
    if (irq_n !== 1'b1) begin
      tests_failed++; $display("FAIL periodic_stop_irq: got %b want 1", irq_n);
    end
  endtask

  task automatic test_timer_oneshot;
    logic [7:0] d;
    bus_write(A_TLO, 8'h02);
    bus_write(A_THI, 8'h00);
    bus_write(A_CTRL, 8'h03);
    idle(2);
    tests_run++;
    if (irq_n !== 1'b1) begin
      tests_failed++; $display("FAIL oneshot_edge2_irq: got %b want 1", irq_n);
    end
    idle(1);
    tests_run++;
    if (irq_n !== 1'b0) begin
      tests_failed++; $display("FAIL oneshot_edge3_irq: got %b want 0", irq_n);
    end
    bus_read(A_CTRL, d);
    tests_run++;
    if (d !== 8'h02) begin
      tests_failed++; $display("FAIL oneshot_ctrl: got %h want 02", d);
    end
    idle(3);
    bus_read(A_CNTLO, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++; $display("FAIL oneshot_cntlo: got %h want 00", d);
    end
    bus_read(A_CNTHI, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++; $display("FAIL oneshot_cnthi: got %h want 00", d);
    end
    bus_write(A_STAT, 8'h01);
    tests_run++;
    if (irq_n !== 1'b1) begin
      tests_failed++; $display("FAIL oneshot_clear_irq: got %b want 1", irq_n);
    end
  endtask

  task automatic test_coherent_read;
    logic [7:0] lo;
    logic [7:0] hi;
    bus_write(A_TLO, 8'h00);
    bus_write(A_THI, 8'h01);
    bus_write(A_CTRL, 8'h01);
    // CNTLO sampled at 0100, counter is 00FF by the CNTHI read
    bus_read(A_CNTLO, lo);
    bus_read(A_CNTHI, hi);
    tests_run++;
    if ({hi, lo} !== 16'h0100) begin
      tests_failed++; $display("FAIL coherent_pair1: got %h want 0100", {hi, lo});
    end
    bus_read(A_CNTLO, lo);
    bus_read(A_CNTHI, hi);
    tests_run++;
    if ({hi, lo} !== 16'h00FE) begin
      tests_failed++; $display("FAIL coherent_pair2: got %h want 00FE", {hi, lo});
    end
    bus_write(A_CTRL, 8'h00);
    bus_write(A_STAT, 8'h01);
  endtask

  task automatic test_simultaneous;
    logic [7:0] d;
    logic [7:0] hi;
    // reload 0 with AR: EXP sets on every enabled edge
    bus_write(A_TLO, 8'h00);
    bus_write(A_THI, 8'h00);
    bus_write(A_CTRL, 8'h07);
    idle(1);
    tests_run++;
    if (irq_n !== 1'b0) begin
      tests_failed++; $display("FAIL reload0_irq: got %b want 0", irq_n);
    end
    bus_write(A_STAT, 8'h01);
    tests_run++;
    if (irq_n !== 1'b0) begin
      tests_failed++; $display("FAIL w1c_vs_expiry_irq: got %b want 0", irq_n);
    end
    bus_write(A_THI, 8'h02);
    tests_run++;
    if (irq_n !== 1'b1) begin
      tests_failed++; $display("FAIL thi_vs_expiry_irq: got %b want 1", irq_n);
    end
    bus_read(A_CNTLO, d);
    bus_read(A_CNTHI, hi);
    tests_run++;
    if ({hi, d} !== 16'h0200) begin
      tests_failed++; $display("FAIL thi_vs_expiry_cnt: got %h want 0200", {hi, d});
    end
    bus_read(A_THI, d);
    tests_run++;
    if (d !== 8'h02) begin
      tests_failed++; $display("FAIL thi_readback: got %h want 02", d);
    end
    bus_write(A_CTRL, 8'h00);
    bus_write(A_STAT, 8'h01);
  endtask
`else
  task automatic test_no_timer;
    logic [7:0] d;
    bus_write(A_THI, 8'h5A);
    bus_read(A_THI, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++; $display("FAIL notimer_thi: got %h want 00", d);
    end
    bus_write(A_TLO, 8'h00);
    bus_write(A_CTRL, 8'h07);
    bus_read(A_CTRL, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++; $display("FAIL notimer_ctrl: got %h want 00", d);
    end
    idle(4);
    tests_run++;
    if (irq_n !== 1'b1) begin
      tests_failed++; $display("FAIL notimer_irq: got %b want 1", irq_n);
    end
  endtask
`endif

  task automatic test_reset_midcycle;
    logic [7:0] d;
    bus_write(A_OUTP, 8'hC3);
    bus_read(A_OUTP, d);
    tests_run++;
    if (d !== 8'hC3) begin
      tests_failed++; $display("FAIL pre_reset_outp: got %h want C3", d);
    end
`ifdef BUS_RESP_TIMER_EN
    bus_write(A_TLO, 8'h00);
    bus_write(A_THI, 8'h00);
    bus_write(A_CTRL, 8'h07);
    idle(1);
    tests_run++;
    if (irq_n !== 1'b0) begin
      tests_failed++; $display("FAIL pre_reset_irq: got %b want 0", irq_n);
    end
`endif
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (irq_n !== 1'b1) begin
      tests_failed++; $display("FAIL async_reset_irq: got %b want 1", irq_n);
    end
    tests_run++;
    if (data_rd !== 8'h00) begin
      tests_failed++; $display("FAIL async_reset_data_rd: got %h want 00", data_rd);
    end
    tests_run++;
    if (out_port !== 8'h00) begin
      tests_failed++; $display("FAIL async_reset_out_port: got %h want 00", out_port);
    end
    #3;
    reset = 1'b0;
    @(posedge ph2);
    #1;
    bus_read(A_CTRL, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++; $display("FAIL post_reset_ctrl: got %h want 00", d);
    end
    idle(4);
    tests_run++;
    if (irq_n !== 1'b1) begin
      tests_failed++; $display("FAIL post_reset_irq: got %b want 1", irq_n);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset   = 1'b1;
    address = 16'h0000;
    data_wr = 8'h00;
    rw      = 1'b1;
    valid   = 1'b0;
    #12;
    test_reset();
    reset = 1'b0;
    @(posedge ph2);
    #1;
    test_ram();
    test_io();
`ifdef BUS_RESP_TIMER_EN
    test_timer_periodic();
    test_timer_oneshot();
    test_coherent_read();
    test_simultaneous();
`else
    test_no_timer();
`endif
    test_reset_midcycle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
